// File: rtl/median9_filter_if.sv
// Sample-stream port bundle for the median9 filter: input sample, strobe/bypass
// controls from the external sequencer, and the result sample.
// Pure wiring, no latency; the filter has no backpressure, so every cycle counts.
interface median9_filter_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] DI;   // input sample
    logic              DSI;  // 1: DI into R0, 0: MCE min into R0
    logic              BYP;  // 1: R7 into R8, 0: MCE max into R8
    logic [DATA_W-1:0] DO;   // result, always equal to R8

    // Sequencer side: drives samples and controls, observes the result.
    modport master (
        output DI,
        output DSI,
        output BYP,
        input  DO
    );

    // Filter side: consumes samples and controls, drives the result.
    modport slave (
        input  DI,
        input  DSI,
        input  BYP,
        output DO
    );
endinterface

// File: rtl/median9_filter.sv
// Nine-register shift ring with one min/max compare element extracting a 9-sample median.
// Latency: 9 load cycles + 40 sequencer-controlled sort cycles; DO is a direct register output.
// No backpressure: every register shifts on every clock, all control comes from DSI/BYP.
module median9_filter #(
    parameter int DATA_W = 8
) (
    input  logic                CLK,
    input  logic                RST,
    median9_filter_if.slave     bus
);

    localparam int NREG = 9;

    // Ring state: r_q[0] is the entry point, r_q[8] is the result register.
    logic [DATA_W-1:0] r_q [NREG];
    logic [DATA_W-1:0] r_d [NREG];

    // Compare element outputs between the last two ring positions.
    logic [DATA_W-1:0] mce_max;
    logic [DATA_W-1:0] mce_min;

    // Unsigned min/max of R7 and R8; on a tie both outputs carry the common value.
    always_comb begin
        mce_max = r_q[8];
        mce_min = r_q[7];
        if (r_q[7] > r_q[8]) begin
            mce_max = r_q[7];
            mce_min = r_q[8];
        end
    end

    // Next-state of the ring: R0 takes the new sample or recirculates the min,
    // R1..R7 shift, R8 either keeps the running max or drops it in favour of R7.
    // DI is only looked at when DSI is high, so an unknown DI during sorting
    // never reaches the ring.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            r_d[i] = r_q[i];
        end
        r_d[0] = bus.DSI ? bus.DI : mce_min;
        for (int i = 1; i < NREG - 1; i++) begin
            r_d[i] = r_q[i-1];
        end
        r_d[8] = bus.BYP ? r_q[7] : mce_max;
    end

    // Ring registers: asynchronous clear so DO drops to zero the moment RST rises.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_q[i] <= r_d[i];
            end
        end
    end

    assign bus.DO = r_q[8];

endmodule

// File: tb/tb_median9_filter.sv
// Directed bench for median9_filter: loads, full sort sequences, extremes,
// duplicates, X on DI while sorting, asynchronous reset mid-sort, random vectors.
module tb_median9_filter;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    median9_filter_if #(.DATA_W(8)) bus ();

    median9_filter #(.DATA_W(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs away from the edge, then settle 1ns past the edge.
    task automatic step(input logic dsi, input logic byp, input logic [7:0] di);
        bus.DSI = dsi;
        bus.BYP = byp;
        bus.DI  = di;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v [9]);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, v[i]);
        end
    endtask

    // 40-cycle sort sequence. When x_di is set DI is driven unknown throughout.
    // When hold_chk is set DO is compared against hold_val after every edge.
    task automatic sort_seq(input bit x_di, input bit hold_chk, input logic [7:0] hold_val);
        logic [7:0] di;
        di = x_di ? 8'bx : 8'd0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8 - k; j++) begin
                step(1'b0, 1'b0, di);
                if (hold_chk) chk("hold", bus.DO, hold_val);
            end
            for (int j = 0; j < k + 1; j++) begin
                step(1'b0, 1'b1, di);
                if (hold_chk) chk("hold", bus.DO, hold_val);
            end
        end
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 1'b0, di);
            if (hold_chk) chk("hold", bus.DO, hold_val);
        end
    endtask

    function automatic logic [7:0] ref_median(input logic [7:0] v [9]);
        logic [7:0] s [9];
        logic [7:0] t;
        s = v;
        for (int i = 1; i < 9; i++) begin
            for (int j = i; j > 0; j--) begin
                if (s[j] < s[j-1]) begin
                    t = s[j]; s[j] = s[j-1]; s[j-1] = t;
                end
            end
        end
        return s[4];
    endfunction

    initial begin
        logic [7:0] v [9];
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        bus.DSI = 1'b0;
        bus.BYP = 1'b0;
        bus.DI  = 8'd0;

        #3;
        chk("reset_do", bus.DO, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Ascending 1..9: DO=1 after load, median 5.
        v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        load(v);
        chk("asc_load", bus.DO, 8'd1);
        sort_seq(1'b0, 1'b0, 8'd0);
        chk("asc_median", bus.DO, 8'd5);
        step(1'b0, 1'b0, 8'd0);

        // Descending 9..1: DO=9 after load, median 5; DI unknown while sorting.
        v = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load(v);
        chk("desc_load", bus.DO, 8'd9);
        sort_seq(1'b1, 1'b0, 8'd0);
        chk("desc_median_xdi", bus.DO, 8'd5);
        step(1'b0, 1'b0, 8'd0);

        // All equal: DO stays 42 through the whole sequence.
        v = '{8'd42, 8'd42, 8'd42, 8'd42, 8'd42, 8'd42, 8'd42, 8'd42, 8'd42};
        load(v);
        chk("dup_load", bus.DO, 8'd42);
        sort_seq(1'b0, 1'b1, 8'd42);
        chk("dup_median", bus.DO, 8'd42);
        step(1'b0, 1'b0, 8'd0);

        // Extremes, unsigned: median 128.
        v = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd128};
        load(v);
        chk("ext_load", bus.DO, 8'd0);
        sort_seq(1'b0, 1'b0, 8'd0);
        chk("ext_median", bus.DO, 8'd128);
        step(1'b0, 1'b0, 8'd0);

        // Five 255s and four 0s: median 255.
        v = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
        load(v);
        chk("ext2_load", bus.DO, 8'd255);
        sort_seq(1'b0, 1'b0, 8'd0);
        chk("ext2_median", bus.DO, 8'd255);
        step(1'b0, 1'b0, 8'd0);

        // Reset mid-sort: DO clears without any clock edge.
        v = '{8'd7, 8'd200, 8'd33, 8'd91, 8'd150, 8'd12, 8'd64, 8'd250, 8'd99};
        load(v);
        for (int j = 0; j < 8; j++) step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 8'd0);
        for (int j = 0; j < 7; j++) step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        chk("pre_rst_nonzero", (bus.DO != 8'd0) ? 8'd1 : 8'd0, 8'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_do", bus.DO, 8'd0);
        @(posedge clk);
        #1;
        chk("held_rst_do", bus.DO, 8'd0);
        rst = 1'b0;

        // Reload after reset: 10..90, median 50.
        v = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
        load(v);
        chk("post_rst_load", bus.DO, 8'd10);
        sort_seq(1'b0, 1'b0, 8'd0);
        chk("post_rst_median", bus.DO, 8'd50);
        step(1'b0, 1'b0, 8'd0);

        // Back-to-back random vectors against a sorted reference.
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 9; i++) v[i] = 8'($urandom_range(0, 255));
            load(v);
            sort_seq(1'b0, 1'b0, 8'd0);
            chk("rand_median", bus.DO, ref_median(v));
            step(1'b0, 1'b0, 8'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
